// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM encoding,
// register offsets, CTRL field positions and the device window base.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

  localparam logic [1:0] OffCtrl   = 2'd0;
  localparam logic [1:0] OffPreset = 2'd1;
  localparam logic [1:0] OffCount  = 2'd2;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  // Only EN, MODE and IM are stored; every other CTRL bit reads 0.
  localparam logic [31:0] CtrlMask = 32'h0000_000F;

  localparam logic [1:0] ModeOneShot  = 2'd0;
  localparam logic [1:0] ModePeriodic = 2'd1;

  // Second device slot on the peripheral bridge.
  localparam logic [31:0] TimerBaseAddr = 32'h0000_7F10;

endpackage

// File: rtl/timer_dev.sv
// Countdown timer on the peripheral bridge: CTRL/PRESET/COUNT registers, a four-state
// load/count/interrupt FSM, byte-merged writes and a level interrupt gated by IM.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic [31:0] ctrl_fsm;

  logic        wr_ctrl, wr_preset;
  logic        en;
  logic [1:0]  mode;

  assign wr_ctrl   = we && (addr == OffCtrl);
  assign wr_preset = we && (addr == OffPreset);
  assign en        = ctrl_q[CtrlEnBit];
  assign mode      = ctrl_q[CtrlModeMsb:CtrlModeLsb];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    ctrl_fsm   = ctrl_q;

    // CPU clear comes first so an FSM set in the same cycle overrides it.
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = StInt;
        end
      end
      StInt: begin
        if (mode == ModePeriodic) begin
          irq_flag_d = 1'b0;
          state_d    = StLoad;
        end else begin
          // One-shot and the reserved modes disable the timer.
          ctrl_fsm[CtrlEnBit] = 1'b0;
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The CPU write is merged over the FSM-updated value, so the CPU wins on EN.
    ctrl_d = ctrl_fsm;
    if (wr_ctrl) ctrl_d = be_merge(ctrl_fsm, wd, be) & CtrlMask;

    preset_d = preset_q;
    if (wr_preset) preset_d = be_merge(preset_q, wd, be);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 32'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rd = 32'd0;
    case (addr)
      OffCtrl:   rd = ctrl_q;
      OffPreset: rd = preset_q;
      OffCount:  rd = count_q;
      default:   rd = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[CtrlImBit];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register map, one-shot and periodic counting,
// masking, byte enables and the write/FSM collision cases.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .be   (be),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a;
    wd   = d;
    be   = b;
    we   = 1'b1;
    tick();
    we = 1'b0;
    be = 4'b0000;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd_reg(a[1:0], v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rd%0d: got %h want 0", a, v);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] v;
    logic [31:0] exp_cnt [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
    logic        exp_irq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'hF);        // E0
    tick();                        // E1
    for (int k = 0; k < 4; k++) begin
      tick();                      // E2..E5
      rd_reg(2'd2, v);
      n_checks++;
      if (v !== exp_cnt[k] || irq !== exp_irq[k]) begin
        n_fail++;
        $display("FAIL m0_step%0d: count=%h irq=%b want count=%h irq=%b",
                 k, v, irq, exp_cnt[k], exp_irq[k]);
      end
    end
    tick();                        // E6
    rd_reg(2'd0, v);
    n_checks++;
    if (v !== 32'h8 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL m0_en_clear: ctrl=%h irq=%b want ctrl=8 irq=1", v, irq);
    end
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL m0_irq_hold: got %b want 1", irq);
    end
    wr(2'd0, 32'h8, 4'hF);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_irq_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_mode1();
    logic [31:0] v;
    logic        exp;
    do_reset();
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);        // E0
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = (k % 4 == 0);
      n_checks++;
      if (irq !== exp) begin
        n_fail++;
        $display("FAIL m1_irq_e%0d: got %b want %b", k, irq, exp);
      end
    end
    rd_reg(2'd0, v);
    n_checks++;
    if (v !== 32'hB) begin
      n_fail++;
      $display("FAIL m1_ctrl: got %h want b", v);
    end
  endtask

  task automatic test_mask_disable();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    for (int k = 0; k < 6; k++) tick();
    rd_reg(2'd2, v);
    n_checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_done: count=%h irq=%b want count=0 irq=0", v, irq);
    end
    wr(2'd0, 32'h8, 4'hF);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_unmask: got %b want 0", irq);
    end

    do_reset();
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'h1, 4'hF);        // E0
    for (int k = 0; k < 6; k++) tick();
    rd_reg(2'd2, v);
    n_checks++;
    if (v !== 32'd6) begin
      n_fail++;
      $display("FAIL dis_pre: count=%h want 6", v);
    end
    wr(2'd0, 32'h0, 4'hF);        // last decrement to 5 happens at this edge
    tick();
    tick();
    tick();
    rd_reg(2'd2, v);
    n_checks++;
    if (v !== 32'd5) begin
      n_fail++;
      $display("FAIL dis_hold: count=%h want 5", v);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'hAABBCCDD, 4'b0011);
    rd_reg(2'd1, v);
    n_checks++;
    if (v !== 32'h0000CCDD) begin
      n_fail++;
      $display("FAIL be_lo: preset=%h want 0000ccdd", v);
    end
    wr(2'd1, 32'h11223344, 4'b1100);
    rd_reg(2'd1, v);
    n_checks++;
    if (v !== 32'h1122CCDD) begin
      n_fail++;
      $display("FAIL be_hi: preset=%h want 1122ccdd", v);
    end
    wr(2'd2, 32'h1234, 4'hF);
    rd_reg(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL count_ro: count=%h want 0", v);
    end
    wr(2'd0, 32'hFFFFFFF0, 4'hF);
    rd_reg(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL ctrl_mask: ctrl=%h want 0", v);
    end
    wr(2'd0, 32'h0000000F, 4'b1110);
    wr(2'd3, 32'hFFFFFFFF, 4'hF);
    rd_reg(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL ctrl_lane0: ctrl=%h want 0", v);
    end
    rd_reg(2'd3, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL addr3: rd=%h want 0", v);
    end
  endtask

  task automatic test_edges();
    logic [31:0] v;
    // PRESET=0 one-shot: LOAD at E1, CNT at E2, INT (irq) at E3.
    do_reset();
    wr(2'd0, 32'h9, 4'hF);        // E0
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL p0_early: irq=%b want 0", irq);
    end
    tick();                        // E3, now in INT
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_irq: irq=%b want 1", irq);
    end
    wr(2'd0, 32'h3, 4'hF);        // collides with the FSM clearing EN
    rd_reg(2'd0, v);
    n_checks++;
    if (v !== 32'h3) begin
      n_fail++;
      $display("FAIL cpu_wins: ctrl=%h want 3", v);
    end

    // PRESET write at the terminal edge: flag set beats the write clear.
    do_reset();
    wr(2'd0, 32'h9, 4'hF);        // E0
    tick();
    tick();
    wr(2'd1, 32'd0, 4'hF);        // E3
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: irq=%b want 1", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    for (int k = 0; k < 4; k++) tick();
    rd_reg(2'd2, v);
    n_checks++;
    if (v !== 32'd8) begin
      n_fail++;
      $display("FAIL mid_pre: count=%h want 8", v);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd_reg(a[1:0], v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL mid_rst_rd%0d: got %h want 0", a, v);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_irq: got %b want 0", irq);
    end
  endtask

  initial begin
    reset = 1'b1;
    addr  = 2'd0;
    we    = 1'b0;
    be    = 4'b0000;
    wd    = 32'd0;
    tick();
    test_reset();
    test_mode0();
    test_mode1();
    test_mask_disable();
    test_byte_enables();
    test_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
